// File: rtl/sram_arbiter_pkg.sv
// Shared types for the IF/MEM single-port SRAM arbiter.
// State encoding and fixed port constants.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_e;

  localparam logic [3:0]  SEL_ALL = 4'hF;
  localparam logic [31:0] ZERO32  = 32'h0;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates IF fetch and MEM access onto one SRAM port.
// MEM wins conflicts; each requester is served once per stall.
import sram_arbiter_pkg::*;

module sram_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        stallreq_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(WAIT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_done_q, if_done_d;
  logic             mem_done_q, mem_done_d;
  logic [31:0]      if_data_q, if_data_d;
  logic [31:0]      mem_data_q, mem_data_d;

  logic if_pend, mem_pend;
  logic last, if_fin, mem_fin;

  assign if_pend    = if_ce_i & ~if_done_q;
  assign mem_pend   = mem_ce_i & ~mem_done_q;
  assign stallreq_o = if_pend | mem_pend;
  assign last       = (cnt_q == '0);
  assign if_fin     = (state_q == ARB_IF) & last;
  assign mem_fin    = (state_q == ARB_MEM) & last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = CNT_LOAD;
        if (mem_pend)     state_d = ARB_MEM;
        else if (if_pend) state_d = ARB_IF;
      end
      ARB_IF, ARB_MEM: begin
        if (last) state_d = ARB_IDLE;
        else      cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = ZERO32;
    ram_sel_o   = 4'h0;
    ram_wdata_o = ZERO32;
    unique case (state_q)
      ARB_IF: begin
        ram_ce_o   = 1'b1;
        ram_addr_o = if_addr_i;
        ram_sel_o  = SEL_ALL;
      end
      ARB_MEM: begin
        ram_ce_o    = 1'b1;
        ram_we_o    = mem_we_i;
        ram_addr_o  = mem_addr_i;
        ram_sel_o   = mem_sel_i;
        ram_wdata_o = mem_data_i;
      end
      default: ;
    endcase
  end

  // A flag set on the final access edge wins over the stall-free clear.
  always_comb begin
    if_done_d  = if_fin  | (if_done_q  & stallreq_o);
    mem_done_d = mem_fin | (mem_done_q & stallreq_o);
    if_data_d  = if_fin ? ram_rdata_i : if_data_q;
    mem_data_d = (mem_fin & ~mem_we_i) ? ram_rdata_i
                                       : mem_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: W=1 and W=3 instances on shared stimulus,
// checked against a transaction-level reference model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_ce = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_wdata = '0;

  logic [31:0] if_data[2];
  logic [31:0] mem_data[2];
  logic        ram_ce[2];
  logic        ram_we[2];
  logic [31:0] ram_addr[2];
  logic [3:0]  ram_sel[2];
  logic [31:0] ram_wdata[2];
  logic [31:0] ram_rdata[2];
  logic        stall[2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0004) return 32'h2408_0001;
    return (a ^ 32'h5A5A_0F0F) + 32'h0000_1357;
  endfunction

  assign ram_rdata[0] = memf(ram_addr[0]);
  assign ram_rdata[1] = memf(ram_addr[1]);

  sram_arbiter #(.WAIT_CYCLES(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data[0]),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_sel_i(mem_sel), .mem_data_i(mem_wdata),
    .mem_data_o(mem_data[0]),
    .ram_ce_o(ram_ce[0]), .ram_we_o(ram_we[0]),
    .ram_addr_o(ram_addr[0]), .ram_sel_o(ram_sel[0]),
    .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0]),
    .stallreq_o(stall[0])
  );

  sram_arbiter #(.WAIT_CYCLES(3), .CNT_W(2)) u_w3 (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data[1]),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_sel_i(mem_sel), .mem_data_i(mem_wdata),
    .mem_data_o(mem_data[1]),
    .ram_ce_o(ram_ce[1]), .ram_we_o(ram_we[1]),
    .ram_addr_o(ram_addr[1]), .ram_sel_o(ram_sel[1]),
    .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1]),
    .stallreq_o(stall[1])
  );

  // Reference model: who owns the port, how many access cycles remain,
  // and whether each requester has already been served this stall.
  localparam int OWN_NONE = 0;
  localparam int OWN_IF   = 1;
  localparam int OWN_MEM  = 2;
  int          wlen[2] = '{1, 3};
  int          own[2];
  int          rem[2];
  bit          ifd[2];
  bit          md[2];
  logic [31:0] m_ifdat[2];
  logic [31:0] m_mdat[2];

  task automatic check(input string tag, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[W=%0d] observed=%h expected=%h",
             tag, wlen[d], obs, exp);
    end
  endtask

  function automatic bit m_stall(input int d);
    return (if_ce & ~ifd[d]) | (mem_ce & ~md[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = OWN_NONE; rem[d] = 0;
      ifd[d] = 0; md[d] = 0;
      m_ifdat[d] = '0; m_mdat[d] = '0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic        ce, we;
      logic [31:0] a, wd;
      logic [3:0]  s;
      ce = 0; we = 0; a = '0; wd = '0; s = '0;
      if (own[d] == OWN_IF) begin
        ce = 1; a = if_addr; s = 4'hF;
      end else if (own[d] == OWN_MEM) begin
        ce = 1; we = mem_we; a = mem_addr; s = mem_sel; wd = mem_wdata;
      end
      check("ram_ce", d, 32'(ram_ce[d]), 32'(ce));
      check("ram_we", d, 32'(ram_we[d]), 32'(we));
      check("ram_addr", d, ram_addr[d], a);
      check("ram_sel", d, 32'(ram_sel[d]), 32'(s));
      check("ram_wdata", d, ram_wdata[d], wd);
      check("stallreq", d, 32'(stall[d]), 32'(m_stall(d)));
      check("if_data", d, if_data[d], m_ifdat[d]);
      check("mem_data", d, mem_data[d], m_mdat[d]);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit st, set_if, set_m;
      st = m_stall(d);
      set_if = 0; set_m = 0;
      if (own[d] != OWN_NONE) begin
        rem[d]--;
        if (rem[d] == 0) begin
          if (own[d] == OWN_IF) begin
            m_ifdat[d] = memf(if_addr); set_if = 1;
          end else begin
            if (!mem_we) m_mdat[d] = memf(mem_addr);
            set_m = 1;
          end
          own[d] = OWN_NONE;
        end
      end else if (mem_ce && !md[d]) begin
        own[d] = OWN_MEM; rem[d] = wlen[d];
      end else if (if_ce && !ifd[d]) begin
        own[d] = OWN_IF; rem[d] = wlen[d];
      end
      if (!st) begin ifd[d] = 0; md[d] = 0; end
      if (set_if) ifd[d] = 1;
      if (set_m) md[d] = 1;
    end
  endtask

  task automatic cyc();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    if_ce = 0; mem_ce = 0; mem_we = 0;
    for (int i = 0; i < 12; i++) begin
      if (own[0] == OWN_NONE && own[1] == OWN_NONE &&
          !ifd[0] && !ifd[1] && !md[0] && !md[1]) break;
      cyc();
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] keep;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst = 1;

    // Single fetch, W=1
    quiet();
    if_ce = 1; if_addr = 32'h8000_0004;
    cyc();
    check("t1_ce_c1", 0, 32'(ram_ce[0]), 32'd1);
    cyc();
    check("t1_ce_c2", 0, 32'(ram_ce[0]), 32'd0);
    check("t1_stall_c2", 0, 32'(stall[0]), 32'd0);
    check("t1_data_c2", 0, if_data[0], 32'h2408_0001);

    // Single fetch, W=3
    quiet();
    if_ce = 1; if_addr = 32'h8000_0100;
    cyc();
    for (int c = 1; c <= 3; c++) begin
      check("t3_ce_on", 1, 32'(ram_ce[1]), 32'd1);
      cyc();
    end
    check("t3_stall_c4", 1, 32'(stall[1]), 32'd0);

    // Conflict, W=1: MEM then IF, two pulses only
    quiet();
    if_ce = 1; if_addr = 32'h8000_0200;
    mem_ce = 1; mem_we = 0; mem_addr = 32'h8040_0010; mem_sel = 4'hF;
    pulses = 0;
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (c == 1) check("cf_mem_c1", 0, ram_addr[0], 32'h8040_0010);
      if (c == 3) check("cf_if_c3", 0, ram_addr[0], 32'h8000_0200);
      if (c == 4) check("cf_stall_c4", 0, 32'(stall[0]), 32'd0);
      if (ram_ce[0]) pulses++;
      cyc();
    end
    check("cf_pulses", 0, 32'(pulses), 32'd2);

    // MEM write leaves mem_data_o alone
    quiet();
    keep = mem_data[0];
    mem_ce = 1; mem_we = 1; mem_addr = 32'h8040_0000;
    mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF;
    cyc();
    check("wr_we", 0, 32'(ram_we[0]), 32'd1);
    check("wr_sel", 0, 32'(ram_sel[0]), 32'd3);
    check("wr_data", 0, ram_wdata[0], 32'hDEAD_BEEF);
    cyc();
    check("wr_keep", 0, mem_data[0], keep);

    // Reset in cycle 1 of a W=3 MEM access
    quiet();
    mem_ce = 1; mem_we = 0; mem_addr = 32'h8040_0020; mem_sel = 4'hF;
    cyc();
    check("rs_ce_pre", 1, 32'(ram_ce[1]), 32'd1);
    rst = 0;
    #1;
    model_reset();
    check_all();
    check("rs_ce_now", 1, 32'(ram_ce[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1;
    pulses = 0;
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (ram_ce[1]) pulses++;
      cyc();
    end
    check("rs_full_len", 1, 32'(pulses), 32'd3);

    // Back-to-back fetches with a new address each stall-free cycle
    quiet();
    if_ce = 1; if_addr = 32'h8000_1000;
    for (int c = 0; c < 24; c++) begin
      if (!m_stall(0) && !m_stall(1) && c > 0)
        if_addr = if_addr + 32'd4;
      cyc();
    end

    // Random traffic; inputs only change while no instance stalls
    quiet();
    for (int c = 0; c < 400; c++) begin
      if (!m_stall(0) && !m_stall(1)) begin
        if_ce = 1'($urandom_range(0, 1));
        mem_ce = 1'($urandom_range(0, 1));
        mem_we = 1'($urandom_range(0, 1));
        if_addr = {16'h8000, 16'($urandom_range(0, 255)) << 2};
        mem_addr = 32'h8040_0000 | 32'($urandom_range(0, 1023));
        mem_sel = 4'($urandom);
        mem_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        if_ce = 0; mem_ce = 0;
      end
      cyc();
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
